cmp_rr_scheduler: RTL

- Round-robin scheduler that shares one N-bit magnitude comparator (l/e/h outputs) among NREQ requesters.
- Each requester offers an operand pair with a valid/ready handshake. The block grants one requester, latches its operands into the comparator, registers the l/e/h result, and returns it on a single tagged response channel with backpressure.
- Sits between client blocks and the comparator datapath. It also provides a completed-operation counter for debug.

---
 rtl/cmp_pkg.sv | 20 ++
 rtl/cmp_core.sv | 25 ++
 rtl/cmp_rr_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the round-robin comparator scheduler.
// Holds the FSM encoding, the default sizes and the id-width helper.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_CNT_W = 16;

    // A single requester still needs a 1-bit id port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_core.sv
// Purely combinational WIDTH-bit magnitude comparator.
// Exactly one of l/e/h is high for any input pair.
module cmp_core #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             l,
    output logic             e,
    output logic             h
);

    generate
        if (SIGNED) begin : g_signed
            assign l = $signed(a) < $signed(b);
        end else begin : g_unsigned
            assign l = a < b;
        end
    endgenerate

    assign e = (a == b);
    assign h = ~l & ~e;

endmodule

// File: rtl/cmp_rr_scheduler.sv
// Shares one comparator among NREQ requesters with round-robin arbitration.
// One operation is in flight at a time: IDLE accepts, CMP evaluates, RESP waits for the consumer.
module cmp_rr_scheduler
    import cmp_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NREQ   = DEF_NREQ,
    parameter bit SIGNED = 1'b0,
    parameter int CNT_W  = DEF_CNT_W,
    localparam int IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic                  resp_l,
    output logic                  resp_e,
    output logic                  resp_h,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    state_t           r_state, w_next;
    logic [IDW-1:0]   r_rr_ptr, r_id, r_resp_id;
    logic [WIDTH-1:0] r_op_a, r_op_b;
    logic             r_resp_valid, r_resp_l, r_resp_e, r_resp_h;
    logic [CNT_W-1:0] r_op_count;
    logic [IDW-1:0]   w_gnt_idx;
    logic             w_gnt_found, w_accept, w_l, w_e, w_h;

    // First valid requester at or above rr_ptr, wrapping; the last winner sits at the bottom.
    always_comb begin
        int j;
        j           = 0;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_gnt_found && req_valid[j]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = IDW'(j);
            end
        end
    end

    assign w_accept  = (r_state == IDLE) && w_gnt_found;
    assign req_ready = w_accept ? (NREQ'(1) << w_gnt_idx) : '0;

    cmp_core #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_core (
        .a (r_op_a),
        .b (r_op_b),
        .l (w_l),
        .e (w_e),
        .h (w_h)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = CMP;
            CMP:     w_next = RESP;
            RESP:    if (r_resp_valid && resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_l     <= 1'b0;
            r_resp_e     <= 1'b0;
            r_resp_h     <= 1'b0;
            r_op_count   <= '0;
        end else begin
            if (w_accept) begin
                r_op_a   <= req_a[w_gnt_idx*WIDTH +: WIDTH];
                r_op_b   <= req_b[w_gnt_idx*WIDTH +: WIDTH];
                r_id     <= w_gnt_idx;
                r_rr_ptr <= (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
            end
            if (r_state == CMP) begin
                r_resp_l     <= w_l;
                r_resp_e     <= w_e;
                r_resp_h     <= w_h;
                r_resp_id    <= r_id;
                r_resp_valid <= 1'b1;
            end
            if (r_state == RESP && r_resp_valid && resp_ready) begin
                r_resp_valid <= 1'b0;
                r_op_count   <= r_op_count + 1'b1;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_l     = r_resp_l;
    assign resp_e     = r_resp_e;
    assign resp_h     = r_resp_h;
    assign busy       = (r_state != IDLE);
    assign op_count   = r_op_count;

endmodule
